// File: rtl/memory_access_stage_pkg.sv
// Shared constants for the memory access (M) stage.
//   - Opcodes of the load/store instructions decoded in M.
//   - Byte-offset and DM word-index widths.
//   - Default data memory depth.
package memory_access_stage_pkg;

    // Load opcodes (instr[31:26])
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;

    // Store opcodes
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    // Byte offset within a word, and word index taken from addr[13:2]
    localparam int unsigned OFF_W    = 2;
    localparam int unsigned DM_IDX_W = 12;

    localparam int unsigned DM_WORDS_DEFAULT = 3072;

endpackage

// File: rtl/data_memory_be.sv
// Data memory with byte-enable writes.
//   clk      in   system clock
//   reset    in   synchronous active-high reset; clears every word
//   i_we     in   write strobe (already qualified by the caller)
//   i_be     in   4-bit byte enable, bit n covers bits [8n+7:8n]
//   i_idx    in   word index (read and write share the address)
//   i_wdata  in   write data, byte lanes already replicated by the caller
//   o_rdata  out  asynchronous read of word i_idx, 0 if beyond the array
module data_memory_be
    import memory_access_stage_pkg::*;
#(
    parameter int unsigned DM_WORDS = DM_WORDS_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_we,
    input  logic [3:0]          i_be,
    input  logic [DM_IDX_W-1:0] i_idx,
    input  logic [31:0]         i_wdata,
    output logic [31:0]         o_rdata
);

    logic [31:0] r_mem [DM_WORDS];
    logic        w_in_range;

    // Indices past the physical array are a hole: writes dropped, reads 0.
    assign w_in_range = 32'(i_idx) < DM_WORDS;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DM_WORDS); i++) begin
                r_mem[i] <= 32'h0;
            end
        end else if (i_we && w_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = w_in_range ? r_mem[i_idx] : 32'h0;

endmodule

// File: rtl/memory_access_stage.sv
// Memory access (M) stage: E/M pipeline register, data memory and M/W register.
//   clk, reset            system clock, synchronous active-high reset
//   E_*                   values leaving the execute stage, captured into E/M
//   M_flush               loads a bubble (all zeros) into E/M
//   M_Forward2            store data after W->M forwarding, used by stores in M
//   M_instr/M_A3/M_WD/M_RD2  registered E/M contents for hazard and forwarding
//   M_addr_err            misaligned load/store currently in M
//   W_*                   M/W pipeline register; W_WD is the final write-back value
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int unsigned DM_WORDS = DM_WORDS_DEFAULT,
    parameter int unsigned PC_W     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     E_instr,
    input  logic [PC_W-1:0] E_PC,
    input  logic [31:0]     E_ALUResult,
    input  logic [31:0]     E_RD2_M,
    input  logic [31:0]     E_WD_M,
    input  logic [4:0]      E_A3_M,
    input  logic            M_flush,
    input  logic [31:0]     M_Forward2,
    output logic [31:0]     M_instr,
    output logic [4:0]      M_A3,
    output logic [31:0]     M_WD,
    output logic [31:0]     M_RD2,
    output logic            M_addr_err,
    output logic [31:0]     W_instr,
    output logic [PC_W-1:0] W_PC,
    output logic [4:0]      W_A3,
    output logic [31:0]     W_WD
);

    // E/M register
    logic [31:0]     r_m_instr;
    logic [PC_W-1:0] r_m_pc;
    logic [31:0]     r_m_alu;
    logic [31:0]     r_m_rd2;
    logic [31:0]     r_m_wd;
    logic [4:0]      r_m_a3;

    // M/W register
    logic [31:0]     r_w_instr;
    logic [PC_W-1:0] r_w_pc;
    logic [4:0]      r_w_a3;
    logic [31:0]     r_w_wd;

    logic [5:0]          w_op;
    logic [OFF_W-1:0]    w_off;
    logic [DM_IDX_W-1:0] w_idx;
    logic                w_is_load;
    logic                w_is_store;
    logic                w_misalign;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata;
    logic                w_we;
    logic [31:0]         w_rdata;
    logic [31:0]         w_shifted;
    logic [31:0]         w_load_ext;
    logic [31:0]         w_load_val;
    logic                w_unused;

    always_ff @(posedge clk) begin
        if (reset || M_flush) begin
            r_m_instr <= 32'h0;
            r_m_pc    <= '0;
            r_m_alu   <= 32'h0;
            r_m_rd2   <= 32'h0;
            r_m_wd    <= 32'h0;
            r_m_a3    <= 5'h0;
        end else begin
            r_m_instr <= E_instr;
            r_m_pc    <= E_PC;
            r_m_alu   <= E_ALUResult;
            r_m_rd2   <= E_RD2_M;
            r_m_wd    <= E_WD_M;
            r_m_a3    <= E_A3_M;
        end
    end

    assign w_op  = r_m_instr[31:26];
    assign w_off = r_m_alu[OFF_W-1:0];
    // Bits above 13 are dropped, so the index wraps modulo 4096.
    assign w_idx = r_m_alu[OFF_W +: DM_IDX_W];

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_misalign = 1'b0;
        case (w_op)
            OP_LW: begin
                w_is_load  = 1'b1;
                w_misalign = (w_off != 2'd0);
            end
            OP_LH, OP_LHU: begin
                w_is_load  = 1'b1;
                w_misalign = w_off[0];
            end
            OP_LB, OP_LBU: w_is_load = 1'b1;
            OP_SW: begin
                w_is_store = 1'b1;
                w_misalign = (w_off != 2'd0);
            end
            OP_SH: begin
                w_is_store = 1'b1;
                w_misalign = w_off[0];
            end
            OP_SB:   w_is_store = 1'b1;
            default: ;
        endcase
    end

    // Narrow stores replicate the data across lanes; the byte enable picks the lane.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = M_Forward2;
        case (w_op)
            OP_SW: w_be = 4'b1111;
            OP_SH: begin
                w_be    = 4'b0011 << w_off;
                w_wdata = {2{M_Forward2[15:0]}};
            end
            OP_SB: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{M_Forward2[7:0]}};
            end
            default: ;
        endcase
    end

    assign w_we = w_is_store && !w_misalign;

    data_memory_be #(
        .DM_WORDS (DM_WORDS)
    ) u_dm (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_idx   (w_idx),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    // Bring the addressed byte/halfword down to bit 0, then extend.
    always_comb begin
        w_shifted  = w_rdata >> {w_off, 3'b000};
        w_load_ext = w_rdata;
        case (w_op)
            OP_LH:   w_load_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            OP_LHU:  w_load_ext = {16'h0, w_shifted[15:0]};
            OP_LB:   w_load_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
            OP_LBU:  w_load_ext = {24'h0, w_shifted[7:0]};
            default: w_load_ext = w_rdata;
        endcase
    end

    assign w_load_val = w_misalign ? 32'h0 : w_load_ext;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_w_instr <= 32'h0;
            r_w_pc    <= '0;
            r_w_a3    <= 5'h0;
            r_w_wd    <= 32'h0;
        end else begin
            r_w_instr <= r_m_instr;
            r_w_pc    <= r_m_pc;
            r_w_a3    <= r_m_a3;
            r_w_wd    <= w_is_load ? w_load_val : r_m_wd;
        end
    end

    assign M_instr    = r_m_instr;
    assign M_A3       = r_m_a3;
    assign M_WD       = r_m_wd;
    assign M_RD2      = r_m_rd2;
    assign M_addr_err = w_misalign;
    assign W_instr    = r_w_instr;
    assign W_PC       = r_w_pc;
    assign W_A3       = r_w_a3;
    assign W_WD       = r_w_wd;

    // Upper address bits are intentionally ignored.
    assign w_unused = ^r_m_alu[31:OFF_W+DM_IDX_W];

endmodule

// File: tb/tb_memory_access_stage.sv
module tb_memory_access_stage;

    localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LHU = 6'b100101;
    localparam logic [5:0] LB = 6'b100000, LBU = 6'b100100;
    localparam logic [5:0] SW = 6'b101011, SH = 6'b101001, SB = 6'b101000;
    localparam int MEM_BYTES = 3072 * 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] E_instr = '0, E_PC = '0, E_ALUResult = '0, E_RD2_M = '0, E_WD_M = '0;
    logic [4:0]  E_A3_M = '0;
    logic        M_flush = 1'b0;
    logic [31:0] M_Forward2 = '0;
    logic [31:0] M_instr, M_WD, M_RD2, W_instr, W_PC, W_WD;
    logic [4:0]  M_A3, W_A3;
    logic        M_addr_err;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    memory_access_stage #(
        .DM_WORDS (3072),
        .PC_W     (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .E_instr     (E_instr),
        .E_PC        (E_PC),
        .E_ALUResult (E_ALUResult),
        .E_RD2_M     (E_RD2_M),
        .E_WD_M      (E_WD_M),
        .E_A3_M      (E_A3_M),
        .M_flush     (M_flush),
        .M_Forward2  (M_Forward2),
        .M_instr     (M_instr),
        .M_A3        (M_A3),
        .M_WD        (M_WD),
        .M_RD2       (M_RD2),
        .M_addr_err  (M_addr_err),
        .W_instr     (W_instr),
        .W_PC        (W_PC),
        .W_A3        (W_A3),
        .W_WD        (W_WD)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]  mdl_mem [MEM_BYTES];
    logic [31:0] m_instr, m_pc, m_alu, m_rd2, m_wd;
    logic [4:0]  m_a3;
    logic [31:0] w_instr, w_pc, w_wd;
    logic [4:0]  w_a3;

    function automatic bit is_ld(input logic [31:0] ins);
        logic [5:0] op = ins[31:26];
        return op == LW || op == LH || op == LHU || op == LB || op == LBU;
    endfunction

    function automatic int st_len(input logic [31:0] ins);
        logic [5:0] op = ins[31:26];
        if (op == SW) return 4;
        if (op == SH) return 2;
        if (op == SB) return 1;
        return 0;
    endfunction

    function automatic bit mis(input logic [31:0] ins, input logic [31:0] a);
        logic [5:0] op = ins[31:26];
        int off = int'(a % 4);
        if (op == LW || op == SW) return off != 0;
        if (op == LH || op == LHU || op == SH) return (off % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [7:0] rb(input int addr);
        if (addr < MEM_BYTES) return mdl_mem[addr];
        return 8'h00;
    endfunction

    function automatic logic [31:0] ld_val(input logic [31:0] ins, input logic [31:0] a);
        logic [5:0]  op = ins[31:26];
        int          b = int'(a % 16384);
        logic [15:0] h;
        logic [7:0]  y;
        if (mis(ins, a)) return 32'h0;
        h = {rb(b + 1), rb(b)};
        y = rb(b);
        case (op)
            LW:      return {rb(b + 3), rb(b + 2), rb(b + 1), rb(b)};
            LH:      return {{16{h[15]}}, h};
            LHU:     return {16'h0, h};
            LB:      return {{24{y[7]}}, y};
            default: return {24'h0, y};
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_BYTES; i++) mdl_mem[i] <= 8'h00;
            {m_instr, m_pc, m_alu, m_rd2, m_wd, m_a3} <= '0;
            {w_instr, w_pc, w_wd, w_a3} <= '0;
        end else begin
            w_instr <= m_instr;
            w_pc    <= m_pc;
            w_a3    <= m_a3;
            w_wd    <= is_ld(m_instr) ? ld_val(m_instr, m_alu) : m_wd;
            if (!mis(m_instr, m_alu)) begin
                for (int k = 0; k < st_len(m_instr); k++) begin
                    if (int'(m_alu % 16384) + k < MEM_BYTES)
                        mdl_mem[int'(m_alu % 16384) + k] <= M_Forward2[k*8 +: 8];
                end
            end
            if (M_flush) begin
                {m_instr, m_pc, m_alu, m_rd2, m_wd, m_a3} <= '0;
            end else begin
                m_instr <= E_instr;
                m_pc    <= E_PC;
                m_alu   <= E_ALUResult;
                m_rd2   <= E_RD2_M;
                m_wd    <= E_WD_M;
                m_a3    <= E_A3_M;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("M_instr", M_instr, m_instr);
            check("M_A3", 32'(M_A3), 32'(m_a3));
            check("M_WD", M_WD, m_wd);
            check("M_RD2", M_RD2, m_rd2);
            check("M_addr_err", 32'(M_addr_err), 32'(mis(m_instr, m_alu)));
            check("W_instr", W_instr, w_instr);
            check("W_PC", W_PC, w_pc);
            check("W_A3", 32'(W_A3), 32'(w_a3));
            check("W_WD", W_WD, w_wd);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic clear_e();
        E_instr = '0; E_PC = '0; E_ALUResult = '0; E_RD2_M = '0; E_WD_M = '0; E_A3_M = '0;
    endtask

    // Issue one memory op, bubble behind it; return addr_err seen in M and W_WD.
    task automatic do_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                         output logic err, output logic [31:0] wd);
        E_instr = {op, 5'd0, 5'd9, 16'h0};
        E_PC = 32'h0040_0000 + addr;
        E_ALUResult = addr;
        E_RD2_M = data;
        E_WD_M = 32'h0;
        E_A3_M = 5'd9;
        @(posedge clk); #1;
        clear_e();
        M_Forward2 = data;
        @(negedge clk); err = M_addr_err;
        @(posedge clk); #1;
        @(negedge clk); wd = W_WD;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e;
        logic [31:0] v, r;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_M_instr", M_instr, 32'h0);
        check("rst_W_WD", W_WD, 32'h0);

        do_op(LW, 32'h0, 32'h0, e, v);             check("lw0_after_reset", v, 32'h0);
        do_op(SW, 32'h10, 32'hDEADBEEF, e, v);
        do_op(LW, 32'h10, 32'h0, e, v);            check("lw_10", v, 32'hDEADBEEF);
        do_op(SB, 32'h11, 32'h0000_0055, e, v);
        do_op(LBU, 32'h11, 32'h0, e, v);           check("lbu_11", v, 32'h0000_0055);
        do_op(LB, 32'h13, 32'h0, e, v);            check("lb_13", v, 32'hFFFF_FFDE);
        do_op(LW, 32'h10, 32'h0, e, v);            check("lw_10_merged", v, 32'hDEAD55EF);
        do_op(SH, 32'h22, 32'h0000_8001, e, v);
        do_op(LH, 32'h22, 32'h0, e, v);            check("lh_22", v, 32'hFFFF_8001);
        do_op(LHU, 32'h22, 32'h0, e, v);           check("lhu_22", v, 32'h0000_8001);
        do_op(SW, 32'h15, 32'hCAFEF00D, e, v);     check("sw_15_err", 32'(e), 32'd1);
        do_op(LW, 32'h14, 32'h0, e, v);            check("lw_14_unchanged", v, 32'h0);
        do_op(LH, 32'h23, 32'h0, e, v);            check("lh_23_err", 32'(e), 32'd1);
        check("lh_23_wd", v, 32'h0);
        do_op(SW, 32'h2FFC, 32'h1357_9BDF, e, v);
        do_op(LW, 32'h2FFC, 32'h0, e, v);          check("lw_last_word", v, 32'h1357_9BDF);
        do_op(SW, 32'h3000, 32'hFFFF_FFFF, e, v);
        do_op(LW, 32'h3000, 32'h0, e, v);          check("lw_hole", v, 32'h0);
        do_op(SW, 32'h4010, 32'hA5A5_5A5A, e, v);
        do_op(LW, 32'h10, 32'h0, e, v);            check("lw_alias", v, 32'hA5A5_5A5A);

        // Flush a store sitting in E
        E_instr = {SW, 26'h0}; E_ALUResult = 32'h30; E_RD2_M = 32'h1111_1111;
        M_flush = 1'b1;
        @(posedge clk); #1;
        M_flush = 1'b0; clear_e(); M_Forward2 = 32'h1111_1111;
        @(negedge clk); check("flush_M_instr", M_instr, 32'h0);
        do_op(LW, 32'h30, 32'h0, e, v);            check("flush_no_write", v, 32'h0);

        // ALU result forwarding path
        E_instr = 32'h0109_4021; E_WD_M = 32'h1234; E_A3_M = 5'd8;
        @(posedge clk); #1;
        clear_e();
        @(negedge clk);
        check("fwd_M_WD", M_WD, 32'h1234);
        check("fwd_M_A3", 32'(M_A3), 32'd8);
        @(posedge clk); #1;
        @(negedge clk);
        check("fwd_W_WD", W_WD, 32'h1234);
        check("fwd_W_A3", 32'(W_A3), 32'd8);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int unsigned sel;
            logic [5:0]  op;
            @(posedge clk); #1;
            sel = $urandom_range(0, 11);
            case (sel)
                0: op = LW;  1: op = LH;  2: op = LHU; 3: op = LB;  4: op = LBU;
                5: op = SW;  6: op = SH;  7: op = SB;  8: op = 6'b001001;
                default: op = 6'b000000;
            endcase
            r = $urandom;
            E_instr = {op, r[25:0]};
            sel = $urandom_range(0, 19);
            if (sel < 14)      E_ALUResult = $urandom_range(0, 127);
            else if (sel < 17) E_ALUResult = $urandom_range(32'h2FF0, 32'h300F);
            else               E_ALUResult = $urandom;
            E_PC = $urandom;
            E_RD2_M = $urandom;
            E_WD_M = $urandom;
            E_A3_M = 5'($urandom_range(0, 31));
            M_flush = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 149) == 0);
            M_Forward2 = $urandom;
        end
        @(posedge clk); #1;
        reset = 1'b0; M_flush = 1'b0; clear_e();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
